// File: rtl/reorder_ctrl.sv
// -----------------------------------------------------------------------------
// reorder_ctrl
// Frame sequencer for the 512-point bit-reversal reorder stage. A frame is
// BEATS beats of 16 samples. Two reorder banks are used ping-pong: the write
// side fills one bank (wr_cnt picks the bit-reversed address set) while the
// read side streams the other bank out in natural order under valid/ready.
//
// Optional feature: define REORDER_CTRL_FLUSH_EN to add a synchronous 'flush'
// input that discards all frames in flight (frame_cnt and ovf_err survive).
//
// Ports:
//   clk, rstn      clock, asynchronous active-low reset
//   flush          (REORDER_CTRL_FLUSH_EN only) synchronous discard of all frames
//   di_en          input beat valid from the FFT stage
//   di_ready       a bank is free to accept input (combinational)
//   wr_en          write strobe = di_en && di_ready (combinational)
//   wr_bank        bank being filled
//   wr_cnt         beat index of the current write
//   rd_bank        bank being streamed out
//   rd_cnt         output beat index, natural order
//   do_en          output beat valid
//   do_ready       downstream accepts the beat
//   frame_done     pulse on the transfer of the last output beat
//   frame_cnt      count of fully streamed frames (wraps)
//   ovf_err        sticky: di_en seen while di_ready=0
// -----------------------------------------------------------------------------
module reorder_ctrl #(
  parameter int BEATS = 32,
  parameter int CNT_W = 5,
  parameter int FRM_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
`ifdef REORDER_CTRL_FLUSH_EN
  input  logic             flush,
`endif
  input  logic             di_en,
  output logic             di_ready,
  output logic             wr_en,
  output logic             wr_bank,
  output logic [CNT_W-1:0] wr_cnt,
  output logic             rd_bank,
  output logic [CNT_W-1:0] rd_cnt,
  output logic             do_en,
  input  logic             do_ready,
  output logic             frame_done,
  output logic [FRM_W-1:0] frame_cnt,
  output logic             ovf_err
);

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic {
    R_IDLE   = 1'b0,
    R_STREAM = 1'b1
  } rd_state_t;

  rd_state_t        r_state;
  rd_state_t        w_state_nxt;
  logic [1:0]       r_full;
  logic [1:0]       w_full_nxt;
  logic             r_wr_bank;
  logic [CNT_W-1:0] r_wr_cnt;
  logic             r_rd_bank;
  logic [CNT_W-1:0] r_rd_cnt;
  logic [FRM_W-1:0] r_frame_cnt;
  logic             r_ovf_err;
  logic             w_flush;
  logic             w_wr_last;
  logic             w_rd_xfer;
  logic             w_rd_last;

`ifdef REORDER_CTRL_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  // Handshake and strobe decode
  assign di_ready   = ~r_full[r_wr_bank];
  assign wr_en      = di_en & di_ready;
  assign w_wr_last  = wr_en & (r_wr_cnt == LAST_BEAT);
  assign do_en      = (r_state == R_STREAM);
  assign w_rd_xfer  = do_en & do_ready;
  assign w_rd_last  = w_rd_xfer & (r_rd_cnt == LAST_BEAT);
  // A flush pre-empts the final transfer, so no completion is reported for it.
  assign frame_done = w_rd_last & ~w_flush;

  assign wr_bank   = r_wr_bank;
  assign wr_cnt    = r_wr_cnt;
  assign rd_bank   = r_rd_bank;
  assign rd_cnt    = r_rd_cnt;
  assign frame_cnt = r_frame_cnt;
  assign ovf_err   = r_ovf_err;

  // Next full flags: a bank is set on its last write and cleared on its last
  // read; both can happen in one cycle on different banks.
  always_comb begin
    w_full_nxt = r_full;
    for (int b = 0; b < 2; b++) begin
      w_full_nxt[b] = (r_full[b] | (w_wr_last & (r_wr_bank == 1'(b))))
                    & ~(w_rd_last & (r_rd_bank == 1'(b)));
    end
  end

  // Read FSM next state. Looking at the next full flags lets streaming start
  // the cycle right after the last write, and lets a back-to-back frame
  // follow with no bubble.
  always_comb begin
    w_state_nxt = r_state;
    if (w_flush) begin
      w_state_nxt = R_IDLE;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (w_full_nxt[r_rd_bank]) begin
            w_state_nxt = R_STREAM;
          end else begin
            w_state_nxt = R_IDLE;
          end
        end
        R_STREAM: begin
          if (w_rd_last) begin
            w_state_nxt = w_full_nxt[~r_rd_bank] ? R_STREAM : R_IDLE;
          end else begin
            w_state_nxt = R_STREAM;
          end
        end
        default: w_state_nxt = R_IDLE;
      endcase
    end
  end

  // Read FSM state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= R_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Bank full flags
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_full <= 2'b00;
    end else if (w_flush) begin
      r_full <= 2'b00;
    end else begin
      r_full <= w_full_nxt;
    end
  end

  // Write beat counter and write bank
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_cnt  <= '0;
      r_wr_bank <= 1'b0;
    end else if (w_flush) begin
      r_wr_cnt  <= '0;
      r_wr_bank <= 1'b0;
    end else if (w_wr_last) begin
      r_wr_cnt  <= '0;
      r_wr_bank <= ~r_wr_bank;
    end else if (wr_en) begin
      r_wr_cnt  <= r_wr_cnt + CNT_W'(1);
    end else begin
      r_wr_cnt  <= r_wr_cnt;
    end
  end

  // Read beat counter and read bank; both hold while the beat is stalled
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rd_cnt  <= '0;
      r_rd_bank <= 1'b0;
    end else if (w_flush) begin
      r_rd_cnt  <= '0;
      r_rd_bank <= 1'b0;
    end else if (w_rd_last) begin
      r_rd_cnt  <= '0;
      r_rd_bank <= ~r_rd_bank;
    end else if (w_rd_xfer) begin
      r_rd_cnt  <= r_rd_cnt + CNT_W'(1);
    end else begin
      r_rd_cnt  <= r_rd_cnt;
    end
  end

  // Completed-frame counter and sticky overflow flag; both survive a flush
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_frame_cnt <= '0;
      r_ovf_err   <= 1'b0;
    end else if (w_flush) begin
      r_frame_cnt <= r_frame_cnt;
      r_ovf_err   <= r_ovf_err;
    end else begin
      r_frame_cnt <= r_frame_cnt + FRM_W'(w_rd_last);
      r_ovf_err   <= r_ovf_err | (di_en & ~di_ready);
    end
  end

endmodule

// File: doc/reorder_ctrl.md
Name: reorder_ctrl

Overview:
Frame sequencer for the 512-point bit-reversal reorder stage; each frame is 32 beats of 16 samples. Manages a two-bank ping-pong reorder buffer. Generates the write beat index and bank for the incoming stream, tracks which banks are full, and streams completed banks out in natural order under a valid/ready handshake. Sits between the last FFT butterfly stage and the output interface.

Parameters:
BEATS, 32, beats per frame (must be a power of two)
CNT_W, 5, beat counter width, log2(BEATS)
FRM_W, 16, width of the completed-frame counter

Ports:
clk  input  1  clock
rstn  input  1  asynchronous active-low reset
di_en  input  1  input beat valid, one 16-sample beat from the FFT stage
di_ready  output  1  a bank is free to accept input; combinational
wr_en  output  1  write strobe to the reorder bank, equal to di_en && di_ready; combinational
wr_bank  output  1  bank being filled
wr_cnt  output  CNT_W  beat index of the current write; selects the bit-reversed address set
rd_bank  output  1  bank being streamed out
rd_cnt  output  CNT_W  output beat index; natural order, 16 consecutive samples per beat
do_en  output  1  output beat valid
do_ready  input  1  downstream accepts the beat
frame_done  output  1  one-cycle pulse on the transfer of the last output beat
frame_cnt  output  FRM_W  count of fully streamed frames; wraps
ovf_err  output  1  sticky flag: di_en arrived while di_ready=0

Behaviour:
- Clock and reset: reset is rstn, asynchronous and active-low; clock is clk.
- Reset values: wr_bank=0, wr_cnt=0, rd_bank=0, rd_cnt=0, do_en=0, frame_done=0, frame_cnt=0, ovf_err=0, full[1:0]=0.
  - Consequently di_ready=1 after reset.
- di_ready = !full[wr_bank].
- Write side:
  - On each wr_en, wr_cnt increments.
  - On the edge where wr_cnt==BEATS-1 and wr_en=1:
    - wr_cnt wraps to 0.
    - full[wr_bank] is set.
    - wr_bank toggles.
  - di_en=0 holds wr_cnt. Gaps inside a frame are legal.
- Overflow:
  - di_en=1 with di_ready=0 drops the beat: no counter change, ovf_err set.
  - ovf_err clears only on reset.
- Read FSM states:
  - R_IDLE: do_en=0. If full[rd_bank]=1, go to R_STREAM at the next edge.
  - R_STREAM: do_en=1.
    - Each do_en && do_ready increments rd_cnt.
    - do_en=1 with do_ready=0 holds rd_cnt and rd_bank stable.
    - On the transfer with rd_cnt==BEATS-1:
      - rd_cnt wraps to 0; full[rd_bank] clears; rd_bank toggles.
      - frame_done pulses for that cycle; frame_cnt increments.
      - If full of the other bank is already 1, stay in R_STREAM with do_en held high (zero bubble). Otherwise go to R_IDLE.
- Latency: the last input beat written at edge N gives do_en=1 in cycle N+1. With do_ready=1 the frame drains in 32 cycles.
- Simultaneous set and clear of different full bits in one cycle: both take effect.
  - The same bit cannot be set and cleared together, because a full bank is never written.
- Continuous di_en=1 with do_ready=1 sustains full throughput with no drops.
- Reset mid-frame: the partial frame is discarded and all state returns to reset values.

Optional Feature:
Macro REORDER_CTRL_FLUSH_EN.
- Defined: adds input flush (1 bit, synchronous).
  - flush=1 at an edge returns all state except frame_cnt and ovf_err to reset values. This discards any partial write frame and any in-progress or pending output frame.
  - flush has priority over di_en and do_ready in that cycle.
  - do_en=0 in the following cycle.
- Not defined: port absent; behaviour as above.

Test Plan:
- Single frame: after reset, di_en=1 for 32 cycles with do_ready=1 -> wr_cnt steps 0..31; wr_bank goes 0->1 at the edge after the 32nd beat; do_en=1 from the next cycle for 32 cycles; rd_cnt steps 0..31; frame_done pulses once; frame_cnt=1.
- Back-to-back frames: di_en=1 for 128 cycles with do_ready=1 -> ovf_err stays 0; do_en stays high continuously from cycle 32 to cycle 127; frame_cnt=3 at cycle 128 and 4 at cycle 160.
- Backpressure: one frame in; do_ready toggled 1,0,1,0... -> each beat holds while ready=0; 64 cycles to drain; rd_cnt never skips.
- Overflow: do_ready=0 and di_en=1 for 65 cycles -> banks 0 and 1 full after 64 beats; di_ready=0; beat 65 dropped; ovf_err=1; wr_cnt=0; wr_bank=0.
- Reset mid-operation: assert rstn=0 at wr_cnt=17 while bank 1 is streaming at rd_cnt=9 -> all outputs at reset values immediately; a new frame afterwards completes normally with frame_cnt=1.
- Flush (macro defined): flush=1 at wr_cnt=10 with one bank full -> next cycle do_en=0, di_ready=1, wr_cnt=0, full=0; frame_cnt unchanged.
